// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared types and constants for the countdown timer.
//   state_t       - controller state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH - default counter width in bits
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 3;

endpackage

// File: rtl/countdown_timer_dff_ar.sv
// dff_ar: WIDTH-bit register with asynchronous active-low reset to zero.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   d     - next value
//   q     - registered value
module dff_ar #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle terminal-count pulse.
// Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN (reload and keep
// running on terminal count instead of passing through DONE).
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load_valid - load request
//   load_value - start value, sampled on a load handshake
//   load_ready - high when a load can be accepted (IDLE or DONE)
//   en         - count enable; counter holds while low
//   abort      - synchronous cancel, highest priority
//   count      - current counter value
//   busy       - high while in RUN
//   done       - registered one-cycle terminal-count pulse
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       state_raw;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_q;
    logic             done_d;
    logic             handshake;

    dff_ar #(.WIDTH(2))     u_state (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_raw));
    dff_ar #(.WIDTH(WIDTH)) u_count (.clk(clk), .rst_n(rst_n), .d(count_d), .q(count_q));
    dff_ar #(.WIDTH(1))     u_done  (.clk(clk), .rst_n(rst_n), .d(done_d),  .q(done_q));

    assign state_q = state_t'(state_raw);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    // Reload value is only consumed by the auto-reload path.
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    dff_ar #(.WIDTH(WIDTH)) u_reload (.clk(clk), .rst_n(rst_n), .d(reload_d), .q(reload_q));

    always_comb begin
        reload_d = reload_q;
        if (handshake && (load_value != '0)) reload_d = load_value;
    end
`endif

    assign load_ready = (state_q != RUN);
    assign busy       = (state_q == RUN);
    assign count      = count_q;
    assign done       = done_q;

    // abort blocks the handshake so a simultaneous load has no effect
    assign handshake  = load_valid && load_ready && !abort;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        // <= 1 rather than == 1 so a zero count can never wrap
                        if (count_q <= WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                            state_d = RUN;
                            count_d = reload_q;
`else
                            state_d = DONE;
                            count_d = '0;
`endif
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE behave alike: accept a load or settle in IDLE
                    if (handshake) begin
                        count_d = load_value;
                        if (load_value != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

endmodule
